dmem_responder: RTL

Multi-cycle data-memory responder serving the MEM-stage load/store requests of the 5-stage pipeline. It holds the pipeline frozen for a configurable access latency. Stores are byte-lane masked, and loads are sign- or zero-extended per funct3. Misaligned and illegal accesses are flagged instead of performed. It replaces the single-cycle data memory and gives the pipeline a realistic slow-memory endpoint to stall against.

---
 rtl/dmem_responder_pkg.sv | 38 +++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared funct3 size/sign constants, responder FSM encoding and request record.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        store;
    logic        err;
  } mem_req_t;

  // Misaligned or illegal size/sign encodings; unsigned variants exist only for loads.
  function automatic logic req_err(input logic store, input logic [2:0] f3, input logic [1:0] off);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = off[0];
      F3_W:    e = (off != 2'b00);
      F3_BU:   e = store;
      F3_HU:   e = store | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous byte-lane write, asynchronous read.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with fixed multi-cycle latency, byte-lane stores and
// sign/zero-extending loads; faulting accesses respond with access_err instead.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        rsp_valid,
  output logic        access_err
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    req_q, cur;
  logic        req, wr_en, done;
  logic [3:0]  be;
  logic [31:0] wd_lane, rword, ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_hi;

  assign req = MemRead | MemWrite;

  // In IDLE the live request is used so a LAT=1 store can commit on the accepting edge.
  always_comb begin
    cur = req_q;
    if (state_q == ST_IDLE) begin
      cur.addr   = addr;
      cur.wdata  = WriteData;
      cur.funct3 = funct3;
      cur.store  = MemWrite;
      cur.err    = req_err(MemWrite, funct3, addr[1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req) begin
        cnt_d   = 4'(LAT - 1);
        state_d = (LAT == 1) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) req_q <= cur;
    end
  end

  assign wr_en = !reset && (state_d == ST_DONE) && cur.store && !cur.err;

  always_comb begin
    be      = '0;
    wd_lane = cur.wdata;
    case (cur.funct3)
      F3_B: begin
        be      = 4'b0001 << cur.addr[1:0];
        wd_lane = {4{cur.wdata[7:0]}};
      end
      F3_H: begin
        be      = cur.addr[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{cur.wdata[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = '0;
    endcase
    if (!wr_en) be = '0;
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .be    (be),
    .waddr (cur.addr[ADDR_W+1:2]),
    .wdata (wd_lane),
    .raddr (req_q.addr[ADDR_W+1:2]),
    .rdata (rword)
  );

  always_comb begin
    byte_v = rword[{req_q.addr[1:0], 3'b000} +: 8];
    half_v = rword[{req_q.addr[1], 4'b0000} +: 16];
    case (req_q.funct3)
      F3_B:    ext = {{24{byte_v[7]}}, byte_v};
      F3_BU:   ext = {24'd0, byte_v};
      F3_H:    ext = {{16{half_v[15]}}, half_v};
      F3_HU:   ext = {16'd0, half_v};
      F3_W:    ext = rword;
      default: ext = '0;
    endcase
  end

  assign done       = (state_q == ST_DONE);
  assign stall      = (state_q == ST_IDLE && req) || (state_q == ST_BUSY);
  assign rsp_valid  = done;
  assign access_err = done && req_q.err;
  assign ReadData   = (done && !req_q.err && !req_q.store) ? ext : '0;

  // Address bits above the word index alias by design.
  assign unused_hi = ^{addr[31:ADDR_W+2], req_q.addr[31:ADDR_W+2], cur.addr[31:ADDR_W+2]};

endmodule
